// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: fixed-latency multiply, 32-step restoring divide, sign fixup.
// Holds busy from accept until the single-cycle done pulse; flush aborts without done.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;        // bit0: MULH / unsigned divide, bit1: remainder
  logic [31:0] a_q, a_d;          // multiplicand, or dividend shifting into quotient
  logic [31:0] b_q, b_d;          // multiplier, or |divisor|
  logic [32:0] rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] result_q, result_d;

  logic signed [63:0] prod;
  logic [32:0]        rem_shift;
  logic [33:0]        diff;
  logic               sgn, a_neg, b_neg;
  logic [31:0]        q_fix, r_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    prod      = $signed(a_q) * $signed(b_q);
    rem_shift = {rem_q[31:0], a_q[31]};
    diff      = {rem_q, a_q[31]} - {2'b00, b_q};
    sgn       = ~op[0];
    a_neg     = sgn & in1[31];
    b_neg     = sgn & in2[31];
    q_fix     = qneg_q ? (~a_q + 32'd1) : a_q;
    r_fix     = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

    case (state_q)
      S_IDLE: begin
        if (start && op[3:1] >= 3'b101) begin
          op_d  = op[1:0];
          a_d   = in1;
          b_d   = in2;
          cnt_d = 5'd0;
          if (!op[2]) begin
            state_d = S_MUL;
          end else if (in2 == 32'd0) begin
            result_d = op[1] ? in1 : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (!op[0] && in1 == 32'h8000_0000 && in2 == 32'hFFFF_FFFF) begin
            result_d = op[1] ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            a_d     = a_neg ? (~in1 + 32'd1) : in1;
            b_d     = b_neg ? (~in2 + 32'd1) : in2;
            rem_d   = 33'd0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == MUL_LAST) begin
          result_d = op_q[0] ? prod[63:32] : prod[31:0];
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DIV: begin
        // One restoring step: keep the subtraction only if it did not go negative.
        if (!diff[33]) begin
          rem_d = diff[32:0];
          a_d   = {a_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          a_d   = {a_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd31) state_d = S_FIXUP;
        else                cnt_d   = cnt_q + 5'd1;
      end
      S_FIXUP: begin
        result_d = op_q[1] ? r_fix : q_fix;
        state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = 5'd0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 33'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed checks of muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        flush = 1'b0;
  logic        ready, busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res = 32'd0;

  muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    case (o)
      4'b1010: return p[31:0];
      4'b1011: return p[63:32];
      4'b1100: if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
               else return 32'(sa / sb);
      4'b1110: if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
               else return 32'(sa % sb);
      4'b1101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 4'b1100) return MC + 1;
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issues one op, scribbles on inputs while busy, checks latency, result and hold.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_r;
    int exp_l, k, busy_bad;
    exp_r = ref_res(o, a, b);
    exp_l = ref_lat(o, a, b);
    @(negedge clk);
    chk({tag, "_ready"}, ready, 1);
    start = 1'b1; op = o; in1 = a; in2 = b;
    k = 0; busy_bad = 0;
    do begin
      @(negedge clk);
      k++;
      start = $urandom_range(0, 1);
      op    = 4'($urandom);
      in1   = $urandom;
      in2   = $urandom;
      if (!busy) busy_bad++;
    end while (!done && k < 60);
    start = 1'b0;
    chk({tag, "_lat"}, k, exp_l);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_busy"}, busy_bad, 0);
    @(negedge clk);
    chk({tag, "_hold"}, {ready, done, result}, {1'b1, 1'b0, exp_r});
    last_res = exp_r;
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("reset_outs", {ready, busy, done, result}, {1'b1, 1'b0, 1'b0, 32'd0});
    rst = 1'b0;

    run_op("mul_neg",   4'b1010, 32'd7, 32'hFFFF_FFFD);
    run_op("mulh_min",  4'b1011, 32'h8000_0000, 32'h8000_0000);
    run_op("mulh_m1",   4'b1011, 32'hFFFF_FFFF, 32'd2);
    run_op("div_neg",   4'b1100, 32'hFFFF_FFEC, 32'd3);
    run_op("rem_neg",   4'b1110, 32'hFFFF_FFEC, 32'd3);
    run_op("divu",      4'b1101, 32'd100, 32'd7);
    run_op("remu",      4'b1111, 32'd100, 32'd7);
    run_op("divu_z",    4'b1101, 32'h1234, 32'd0);
    run_op("rem_z",     4'b1110, 32'h1234, 32'd0);
    run_op("rem_ovf",   4'b1110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_ovf",   4'b1100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_big",  4'b1101, 32'h8000_0000, 32'hFFFF_FFFF);

    // Invalid op codes with start are ignored.
    @(negedge clk);
    start = 1'b1; op = 4'b0000;
    @(negedge clk);
    chk("badop_ready", ready, 1);
    op = 4'b1001;
    watch_no_done("badop_nodone", 5);
    start = 1'b0;

    // Flush in the same cycle as start: nothing accepted.
    start = 1'b1; op = 4'b1010; in1 = 32'd5; in2 = 32'd5; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_ready", ready, 1);
    watch_no_done("flush_start_nodone", 5);

    // Flush mid-divide.
    start = 1'b1; op = 4'b1100; in1 = 32'd1000; in2 = 32'd7;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {ready, busy, done}, {1'b1, 1'b0, 1'b0});
    chk("flush_res", result, last_res);
    watch_no_done("flush_nodone", 40);
    run_op("mul_after_flush", 4'b1010, 32'd3, 32'd4);

    // Reset mid-divide.
    @(negedge clk);
    start = 1'b1; op = 4'b1101; in1 = 32'd12345; in2 = 32'd11;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid", {ready, busy, done, result}, {1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    watch_no_done("rst_nodone", 40);
    last_res = 32'd0;

    for (int t = 0; t < 40; t++) begin
      ro = 4'(4'b1010 + $urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
        1: rb = 32'd0;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'($signed(-$urandom_range(1, 9)));
        default: ;
      endcase
      run_op("rand", ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
